// File: rtl/mapper45_if.sv
// Core/fabric-side signal bundle for the 45xx MAP unit.
// master = core/hypervisor side, slave = mapper45_seq.
interface mapper45_if #(
    parameter int PA_WIDTH = 20,
    parameter int SET_W    = 1
);
    logic                phi2;
    logic                sync;
    logic [7:0]          data_i;
    logic [7:0]          wr_data;
    logic                map_start;
    logic                map_byte_valid;
    logic [SET_W-1:0]    map_set_sel;
    logic [SET_W-1:0]    active_set;
    logic                hv_wr;
    logic [1:0]          hv_sel;
    logic [SET_W-1:0]    hv_set;
    logic [7:0]          hv_rd_data;
    logic                hv_wr_reject;
    logic [15:0]         core_address_next;
    logic [PA_WIDTH-1:0] address_next;
    logic [PA_WIDTH-1:0] address;
    logic                map_next;
    logic                map;
    logic                ext_irq;
    logic                ext_nmi;
    logic                cpu_irq;
    logic                cpu_nmi;
    logic                busy;

    modport master (
        output phi2, sync, data_i, wr_data, map_start, map_byte_valid,
        output map_set_sel, active_set, hv_wr, hv_sel, hv_set,
        output core_address_next, ext_irq, ext_nmi,
        input  hv_rd_data, hv_wr_reject, address_next, address,
        input  map_next, map, cpu_irq, cpu_nmi, busy
    );

    modport slave (
        input  phi2, sync, data_i, wr_data, map_start, map_byte_valid,
        input  map_set_sel, active_set, hv_wr, hv_sel, hv_set,
        input  core_address_next, ext_irq, ext_nmi,
        output hv_rd_data, hv_wr_reject, address_next, address,
        output map_next, map, cpu_irq, cpu_nmi, busy
    );
endinterface

// File: rtl/mapper45_seq.sv
// 45xx MAP unit: address translation, MAP byte sequencer, EOM commit.
// Optional MAPPER_MB_SEL_EN: megabyte select via 8'h0F marker, NMI unmasked.
module mapper45_seq #(
    parameter int PA_WIDTH = 20,
    parameter int NSETS    = 2,
    parameter int SET_W    = 1
) (
    input  logic       clk,
    input  logic       reset,
    mapper45_if.slave  bus
);
    localparam int OW = PA_WIDTH - 8;
    localparam logic [OW-1:0] HI_RESET = OW'(12'hF00);

    typedef enum logic [2:0] {
        IDLE, LD_A, LD_X, LD_Y, LD_Z, PEND
    } state_t;

    state_t state, state_nx;

    logic [7:0] sh_a, sh_x, sh_y, sh_z;
    logic [OW-1:0] off [NSETS][2];
    logic [3:0]    en  [NSETS][2];

    logic int_enable;
    logic reject;
    logic [PA_WIDTH-1:0] addr_q;
    logic map_q;

    logic eom, load, commit, hv_ok;
    logic [OW-1:0] c_off0, c_off1;
    logic [3:0] c_en0, c_en1;
    logic [OW-1:0] t_off;
    logic t_hit;
    logic [PA_WIDTH-1:0] pa, t_addr;

    assign eom   = bus.sync & bus.phi2 & (bus.data_i == 8'hEA);
    assign load  = bus.map_byte_valid & bus.phi2;
    assign hv_ok = bus.hv_wr & (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        if (bus.map_start) begin
            state_nx = LD_A;
        end else begin
            unique case (state)
                IDLE: state_nx = IDLE;
                LD_A: if (load) state_nx = LD_X;
                LD_X: if (load) state_nx = LD_Y;
                LD_Y: if (load) state_nx = LD_Z;
                LD_Z: if (load) state_nx = PEND;
                PEND: if (eom) begin
                    state_nx = IDLE;
                    commit   = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.map_start) begin
            sh_a <= '0;
            sh_x <= '0;
            sh_y <= '0;
            sh_z <= '0;
        end else if (load) begin
            case (state)
                LD_A:    sh_a <= bus.wr_data;
                LD_X:    sh_x <= bus.wr_data;
                LD_Y:    sh_y <= bus.wr_data;
                LD_Z:    sh_z <= bus.wr_data;
                default: ;
            endcase
        end
    end

    // Values written to the live set when the pending MAP commits
    always_comb begin
`ifdef MAPPER_MB_SEL_EN
        c_off0 = off[bus.map_set_sel][0];
        c_off1 = off[bus.map_set_sel][1];
`else
        c_off0 = '0;
        c_off1 = '0;
`endif
        c_off0[11:0] = {sh_x[3:0], sh_a};
        c_off1[11:0] = {sh_z[3:0], sh_y};
        c_en0 = sh_x[7:4];
        c_en1 = sh_z[7:4];
`ifdef MAPPER_MB_SEL_EN
        if (sh_x == 8'h0F) begin
            c_off0 = off[bus.map_set_sel][0];
            c_off0[OW-1 -: 8] = sh_a;
            c_en0 = en[bus.map_set_sel][0];
        end
        if (sh_z == 8'h0F) begin
            c_off1 = off[bus.map_set_sel][1];
            c_off1[OW-1 -: 8] = sh_y;
            c_en1 = en[bus.map_set_sel][1];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NSETS; s++) begin
                for (int h = 0; h < 2; h++) begin
                    off[s][h] <= '0;
                    en[s][h]  <= '0;
                end
            end
            off[NSETS-1][1] <= HI_RESET;
            en[NSETS-1][1]  <= 4'b0011;
        end else if (commit) begin
            off[bus.map_set_sel][0] <= c_off0;
            off[bus.map_set_sel][1] <= c_off1;
            en[bus.map_set_sel][0]  <= c_en0;
            en[bus.map_set_sel][1]  <= c_en1;
        end else if (hv_ok) begin
            unique case (bus.hv_sel)
                2'd3: off[bus.hv_set][0][7:0] <= bus.wr_data;
                2'd2: {en[bus.hv_set][0], off[bus.hv_set][0][11:8]}
                          <= bus.wr_data;
                2'd1: off[bus.hv_set][1][7:0] <= bus.wr_data;
                2'd0: {en[bus.hv_set][1], off[bus.hv_set][1][11:8]}
                          <= bus.wr_data;
            endcase
        end
    end

    always_comb begin
        bus.hv_rd_data = '0;
        unique case (bus.hv_sel)
            2'd3: bus.hv_rd_data = off[bus.hv_set][0][7:0];
            2'd2: bus.hv_rd_data = {en[bus.hv_set][0],
                                    off[bus.hv_set][0][11:8]};
            2'd1: bus.hv_rd_data = off[bus.hv_set][1][7:0];
            2'd0: bus.hv_rd_data = {en[bus.hv_set][1],
                                    off[bus.hv_set][1][11:8]};
        endcase
    end

    // Translation wraps modulo 2^PA_WIDTH by truncation of the sum
    assign t_off  = off[bus.active_set][bus.core_address_next[15]];
    assign t_hit  = en[bus.active_set][bus.core_address_next[15]]
                      [bus.core_address_next[14:13]];
    assign pa     = {t_off, 8'h00} + PA_WIDTH'(bus.core_address_next);
    assign t_addr = t_hit ? pa : PA_WIDTH'(bus.core_address_next);

    always_ff @(posedge clk) begin
        if (reset) begin
            int_enable <= 1'b1;
            reject     <= 1'b0;
            addr_q     <= '0;
            map_q      <= 1'b0;
        end else begin
            reject <= bus.hv_wr & (state != IDLE);
            if (bus.map_start)  int_enable <= 1'b0;
            else if (eom)       int_enable <= 1'b1;
            if (bus.phi2) begin
                addr_q <= t_addr;
                map_q  <= t_hit;
            end
        end
    end

    assign bus.address_next = bus.phi2 ? t_addr : addr_q;
    assign bus.map_next     = bus.phi2 ? t_hit : map_q;
    assign bus.address      = addr_q;
    assign bus.map          = map_q;
    assign bus.hv_wr_reject = reject;
    assign bus.busy         = (state != IDLE);
    assign bus.cpu_irq      = bus.ext_irq & int_enable;
`ifdef MAPPER_MB_SEL_EN
    assign bus.cpu_nmi      = bus.ext_nmi;
`else
    assign bus.cpu_nmi      = bus.ext_nmi & int_enable;
`endif
endmodule

// File: tb/tb_mapper45_seq.sv
// Directed bench for mapper45_seq: translation, MAP sequencing, hypervisor
// access, interrupt masking and reset abort.
module tb_mapper45_seq;
`ifdef MAPPER_MB_SEL_EN
    localparam int PA = 28;
    localparam logic [31:0] WRAP_EXP = 32'h0101345;
    localparam logic [31:0] NMI_MASKED = 32'd1;
`else
    localparam int PA = 20;
    localparam logic [31:0] WRAP_EXP = 32'h01345;
    localparam logic [31:0] NMI_MASKED = 32'd0;
`endif

    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;

    mapper45_if #(.PA_WIDTH(PA), .SET_W(1)) bus ();

    mapper45_seq #(.PA_WIDTH(PA), .NSETS(2), .SET_W(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic map_load(input logic [7:0] a, input logic [7:0] x,
                            input logic [7:0] y, input logic [7:0] z);
        bus.map_start = 1'b1;
        tick();
        bus.map_start = 1'b0;
        bus.map_byte_valid = 1'b1;
        bus.wr_data = a; tick();
        bus.wr_data = x; tick();
        bus.wr_data = y; tick();
        bus.wr_data = z; tick();
        bus.map_byte_valid = 1'b0;
    endtask

    task automatic eom();
        bus.sync = 1'b1;
        bus.data_i = 8'hEA;
        tick();
        bus.sync = 1'b0;
        bus.data_i = 8'h00;
    endtask

    initial begin
        reset = 1'b1;
        bus.phi2 = 1'b0;
        bus.sync = 1'b0;
        bus.data_i = 8'h00;
        bus.wr_data = 8'h00;
        bus.map_start = 1'b0;
        bus.map_byte_valid = 1'b0;
        bus.map_set_sel = 1'b0;
        bus.active_set = 1'b1;
        bus.hv_wr = 1'b0;
        bus.hv_sel = 2'd0;
        bus.hv_set = 1'b1;
        bus.core_address_next = 16'h0000;
        bus.ext_irq = 1'b1;
        bus.ext_nmi = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_reject", 32'(bus.hv_wr_reject), 32'd0);
        chk("rst_addr", 32'(bus.address), 32'h0);
        chk("rst_map", 32'(bus.map), 32'd0);
        chk("rst_irq", 32'(bus.cpu_irq), 32'd1);
        chk("rst_nmi", 32'(bus.cpu_nmi), 32'd1);
        chk("rst_rd_set1_z", 32'(bus.hv_rd_data), 32'h3F);

        bus.phi2 = 1'b1;
        bus.core_address_next = 16'hA123;
        #1;
        chk("comb_a123", 32'(bus.address_next), 32'hFA123);
        chk("comb_map_a123", 32'(bus.map_next), 32'd1);
        tick();
        chk("reg_a123", 32'(bus.address), 32'hFA123);
        chk("reg_map_a123", 32'(bus.map), 32'd1);
        bus.core_address_next = 16'h2000;
        tick();
        chk("reg_2000", 32'(bus.address), 32'h02000);
        chk("reg_map_2000", 32'(bus.map), 32'd0);
        bus.phi2 = 1'b0;
        bus.core_address_next = 16'hA123;
        #1;
        chk("hold_addr", 32'(bus.address_next), 32'h02000);
        chk("hold_map", 32'(bus.map_next), 32'd0);
        bus.phi2 = 1'b1;

        // MAP set 0 with a hypervisor write attempt during LD_X
        bus.map_set_sel = 1'b0;
        bus.map_start = 1'b1;
        tick();
        bus.map_start = 1'b0;
        chk("seq_busy", 32'(bus.busy), 32'd1);
        chk("seq_irq_mask", 32'(bus.cpu_irq), 32'd0);
        chk("seq_nmi", 32'(bus.cpu_nmi), NMI_MASKED);
        bus.map_byte_valid = 1'b1;
        bus.wr_data = 8'h40;
        tick();
        bus.map_byte_valid = 1'b0;
        bus.hv_wr = 1'b1;
        bus.hv_set = 1'b0;
        bus.hv_sel = 2'd3;
        bus.wr_data = 8'h55;
        tick();
        bus.hv_wr = 1'b0;
        chk("hv_reject", 32'(bus.hv_wr_reject), 32'd1);
        chk("hv_rd_unchanged", 32'(bus.hv_rd_data), 32'h00);
        tick();
        chk("hv_reject_pulse", 32'(bus.hv_wr_reject), 32'd0);
        bus.map_byte_valid = 1'b1;
        bus.wr_data = 8'h20; tick();
        bus.wr_data = 8'h40; tick();
        bus.wr_data = 8'h20; tick();
        bus.map_byte_valid = 1'b0;
        bus.active_set = 1'b0;
        bus.core_address_next = 16'h2000;
        tick();
        chk("pend_addr", 32'(bus.address), 32'h02000);
        chk("pend_busy", 32'(bus.busy), 32'd1);
        chk("pend_irq", 32'(bus.cpu_irq), 32'd0);
        eom();
        chk("eom_busy", 32'(bus.busy), 32'd0);
        chk("eom_irq", 32'(bus.cpu_irq), 32'd1);
        chk("eom_comb_2000", 32'(bus.address_next), 32'h06000);
        chk("eom_map_2000", 32'(bus.map_next), 32'd1);
        bus.core_address_next = 16'hA000;
        tick();
        chk("map_a000", 32'(bus.address), 32'h0E000);
        chk("map_a000_flag", 32'(bus.map), 32'd1);

        // Offset wrap
        map_load(8'hF0, 8'h2F, 8'h00, 8'h00);
        eom();
        bus.core_address_next = 16'h2345;
        tick();
        chk("wrap_2345", 32'(bus.address), WRAP_EXP);
        chk("wrap_map", 32'(bus.map), 32'd1);
        bus.core_address_next = 16'hA000;
        tick();
        chk("hi_off_a000", 32'(bus.address), 32'h0A000);
        chk("hi_off_map", 32'(bus.map), 32'd0);

        // EOM before PEND unmasks but does not commit
        bus.map_start = 1'b1;
        tick();
        bus.map_start = 1'b0;
        bus.map_byte_valid = 1'b1;
        bus.wr_data = 8'h77;
        tick();
        bus.map_byte_valid = 1'b0;
        eom();
        chk("early_eom_irq", 32'(bus.cpu_irq), 32'd1);
        chk("early_eom_busy", 32'(bus.busy), 32'd1);
        bus.hv_set = 1'b0;
        bus.hv_sel = 2'd3;
        #1;
        chk("early_eom_rd", 32'(bus.hv_rd_data), 32'hF0);

        // Restart then reset mid-sequence
        bus.map_start = 1'b1;
        tick();
        bus.map_start = 1'b0;
        chk("restart_irq", 32'(bus.cpu_irq), 32'd0);
        bus.map_byte_valid = 1'b1;
        bus.wr_data = 8'h99;
        tick();
        bus.map_byte_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_irq", 32'(bus.cpu_irq), 32'd1);
        chk("abort_rd_a", 32'(bus.hv_rd_data), 32'h00);
        bus.hv_set = 1'b1;
        bus.hv_sel = 2'd0;
        #1;
        chk("abort_rd_z", 32'(bus.hv_rd_data), 32'h3F);

        // Hypervisor writes while idle
        bus.hv_sel = 2'd3;
        bus.wr_data = 8'h12;
        bus.hv_wr = 1'b1;
        tick();
        bus.hv_wr = 1'b0;
        chk("hv_idle_rd", 32'(bus.hv_rd_data), 32'h12);
        chk("hv_idle_noreject", 32'(bus.hv_wr_reject), 32'd0);
        bus.hv_sel = 2'd2;
        bus.wr_data = 8'h21;
        bus.hv_wr = 1'b1;
        tick();
        bus.hv_wr = 1'b0;
        bus.active_set = 1'b1;
        bus.core_address_next = 16'h2000;
        tick();
        chk("hv_xlate", 32'(bus.address), 32'h13200);
        chk("hv_xlate_map", 32'(bus.map), 32'd1);

`ifdef MAPPER_MB_SEL_EN
        // Megabyte select for the low half of set 0
        bus.hv_set = 1'b0;
        bus.hv_sel = 2'd2;
        bus.wr_data = 8'h20;
        bus.hv_wr = 1'b1;
        tick();
        bus.hv_wr = 1'b0;
        bus.map_set_sel = 1'b0;
        map_load(8'h12, 8'h0F, 8'h00, 8'h00);
        eom();
        chk("mb_rd_x", 32'(bus.hv_rd_data), 32'h20);
        bus.active_set = 1'b0;
        bus.core_address_next = 16'h2000;
        tick();
        chk("mb_xlate", 32'(bus.address), 32'h1202000);
        chk("mb_map", 32'(bus.map), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
